// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary MAC array computing C = A * B.
// One job is accepted per start strobe. The controller then issues skewed
// row/column buffer reads, drives the corner cal_en/cal_done pair, waits out
// the drain window and pulses done. Every output comes straight from a flop.
module systolic_seq_ctrl #(
    parameter int N      = 4,
    parameter int K_W    = 8,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        a_rd_en,
    output logic [N*ADDR_W-1:0] a_rd_addr,
    output logic [N-1:0]        b_rd_en,
    output logic [N*ADDR_W-1:0] b_rd_addr,
    output logic                cal_en,
    output logic                cal_done,
    output logic [K_W:0]        res_cnt
);

    // One spare bit over res_cnt keeps the internal cycle arithmetic free of wrap.
    localparam int CW = K_W + 2;

    // Reject parameter sets whose longest job would not fit the cycle counter.
    generate
        if ((N > (2 ** (K_W - 1))) || (ADDR_W < K_W)) begin : g_param_check
            $error("systolic_seq_ctrl: need N <= 2**(K_W-1) and ADDR_W >= K_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [CW-1:0]       t_q, t_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N-1:0]        rd_en_q, rd_en_d;
    logic [N*ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                cal_en_q, cal_en_d;
    logic                cal_done_q, cal_done_d;
    logic [K_W:0]        res_cnt_q, res_cnt_d;

    logic                active_s;
    logic [CW-1:0]       kk_s, end_s, feed_last_s, flush_last_s;

    // Cycle in which done is shown: cycle 1 for an empty job, else K+2N+1.
    function automatic logic [CW-1:0] job_end(input logic [K_W-1:0] k);
        logic [CW-1:0] e;
        if (k == '0) begin
            e = CW'(1);
        end else begin
            e = CW'(k) + CW'(2 * N + 1);
        end
        return e;
    endfunction

    // Next job cycle, next state and the output values belonging to that cycle.
    always_comb begin
        k_d      = k_q;
        t_d      = t_q;
        active_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d      = k_len;
                    t_d      = '0;
                    active_s = 1'b1;
                end else begin
                    t_d = '0;
                end
            end
            ST_FIN: begin
                if (t_q >= job_end(k_q)) begin
                    t_d = '0;
                    k_d = '0;
                end else begin
                    // Empty job sits in FIN for cycle 0 and shows done in cycle 1.
                    t_d      = t_q + CW'(1);
                    active_s = 1'b1;
                end
            end
            default: begin
                t_d      = t_q + CW'(1);
                active_s = 1'b1;
            end
        endcase

        kk_s         = CW'(k_d);
        end_s        = job_end(k_d);
        feed_last_s  = kk_s + CW'(N) - CW'(2);
        flush_last_s = kk_s + CW'(N);

        if (active_s) begin
            if ((k_d == '0) || (t_d >= end_s)) begin
                state_d = ST_FIN;
            end else if (t_d <= feed_last_s) begin
                state_d = ST_FEED;
            end else if (t_d <= flush_last_s) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = ST_DRAIN;
            end
        end else begin
            state_d = ST_IDLE;
        end

        busy_d     = (state_d == ST_FEED) || (state_d == ST_FLUSH) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_FIN) && (t_d == end_s);
        cal_en_d   = busy_d && (t_d >= CW'(1)) && (t_d <= kk_s);
        cal_done_d = busy_d && (k_d != '0) && (t_d == (kk_s + CW'(1)));
        if (state_d == ST_IDLE) begin
            res_cnt_d = '0;
        end else begin
            res_cnt_d = t_d[K_W:0];
        end

        // Buffer i is read in cycles i .. i+K-1 at address t-i.
        rd_en_d   = '0;
        rd_addr_d = '0;
        for (int i = 0; i < N; i++) begin
            if (busy_d && (t_d >= CW'(i)) && (t_d < (CW'(i) + kk_s))) begin
                rd_en_d[i]                    = 1'b1;
                rd_addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(t_d[K_W-1:0] - K_W'(i));
            end else begin
                rd_en_d[i] = 1'b0;
            end
        end
    end

    // State, latched K, cycle counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            t_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= '0;
            rd_addr_q  <= '0;
            cal_en_q   <= 1'b0;
            cal_done_q <= 1'b0;
            res_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            t_q        <= t_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            cal_en_q   <= cal_en_d;
            cal_done_q <= cal_done_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    // Rows and columns share one skew schedule, so both sides use the same flops.
    assign busy      = busy_q;
    assign done      = done_q;
    assign a_rd_en   = rd_en_q;
    assign a_rd_addr = rd_addr_q;
    assign b_rd_en   = rd_en_q;
    assign b_rd_addr = rd_addr_q;
    assign cal_en    = cal_en_q;
    assign cal_done  = cal_done_q;
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: each accepted start pushes the
// expected reads, cal pulses, done pulse and busy window of that job into
// queues; a monitor on the falling edge pops and compares them.
module tb_systolic_seq_ctrl;

    localparam int N      = 4;
    localparam int K_W    = 8;
    localparam int ADDR_W = 8;

    logic                clk = 1'b0;
    logic                sys_rst;
    logic                start;
    logic [K_W-1:0]      k_len;
    logic                busy;
    logic                done;
    logic [N-1:0]        a_rd_en;
    logic [N*ADDR_W-1:0] a_rd_addr;
    logic [N-1:0]        b_rd_en;
    logic [N*ADDR_W-1:0] b_rd_addr;
    logic                cal_en;
    logic                cal_done;
    logic [K_W:0]        res_cnt;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.N(N), .K_W(K_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .cal_en    (cal_en),
        .cal_done  (cal_done),
        .res_cnt   (res_cnt)
    );

    typedef struct { int cyc; int addr; } ev_t;
    typedef struct { int first; int last; } win_t;

    ev_t  a_q [N][$];
    ev_t  b_q [N][$];
    int   cal_q[$];
    int   cald_q[$];
    int   done_q[$];
    win_t win_q[$];

    int cyc       = 0;
    int n_cmp     = 0;
    int n_err     = 0;
    int idle_from = 0;
    bit mon_on    = 1'b0;
    bit m_exp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    // Reference model of one job, taken straight from the timing rules.
    function automatic void accept(int k, int base);
        for (int i = 0; i < N; i++) begin
            for (int t = i; t < i + k; t++) begin
                a_q[i].push_back('{cyc: base + t, addr: t - i});
                b_q[i].push_back('{cyc: base + t, addr: t - i});
            end
        end
        for (int t = 1; t <= k; t++) cal_q.push_back(base + t);
        if (k > 0) begin
            cald_q.push_back(base + k + 1);
            done_q.push_back(base + k + 2 * N + 1);
            win_q.push_back('{first: base, last: base + k + 2 * N});
            idle_from = base + k + 2 * N + 2;
        end else begin
            done_q.push_back(base + 1);
            idle_from = base + 2;
        end
    endfunction

    // Drop everything the aborted job would have produced after cycle c.
    function automatic void purge_after(int c);
        for (int i = 0; i < N; i++) begin
            while (a_q[i].size() > 0 && a_q[i][$].cyc > c) void'(a_q[i].pop_back());
            while (b_q[i].size() > 0 && b_q[i][$].cyc > c) void'(b_q[i].pop_back());
        end
        while (cal_q.size() > 0 && cal_q[$] > c) void'(cal_q.pop_back());
        while (cald_q.size() > 0 && cald_q[$] > c) void'(cald_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
        while (win_q.size() > 0 && win_q[$].first > c) void'(win_q.pop_back());
        if (win_q.size() > 0 && win_q[$].last > c) win_q[win_q.size() - 1].last = c;
    endfunction

    function automatic void ev_check(bit is_b, int i, bit en, int addr);
        bit    exp_en;
        int    exp_addr;
        string nm;
        nm       = $sformatf("%s_rd%0d", is_b ? "b" : "a", i);
        exp_en   = 1'b0;
        exp_addr = 0;
        if (is_b) begin
            if (b_q[i].size() > 0 && b_q[i][0].cyc == cyc) begin
                exp_en   = 1'b1;
                exp_addr = b_q[i][0].addr;
                void'(b_q[i].pop_front());
            end
        end else begin
            if (a_q[i].size() > 0 && a_q[i][0].cyc == cyc) begin
                exp_en   = 1'b1;
                exp_addr = a_q[i][0].addr;
                void'(a_q[i].pop_front());
            end
        end
        check({nm, "_en"}, int'(en), int'(exp_en));
        check({nm, "_addr"}, addr, exp_addr);
    endfunction

    // Monitor: compare every DUT output against the queued expectations.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < N; i++) begin
                ev_check(1'b0, i, a_rd_en[i], int'(a_rd_addr[i*ADDR_W +: ADDR_W]));
                ev_check(1'b1, i, b_rd_en[i], int'(b_rd_addr[i*ADDR_W +: ADDR_W]));
            end
            m_exp = (cal_q.size() > 0) && (cal_q[0] == cyc);
            if (m_exp) void'(cal_q.pop_front());
            check("cal_en", int'(cal_en), int'(m_exp));
            m_exp = (cald_q.size() > 0) && (cald_q[0] == cyc);
            if (m_exp) void'(cald_q.pop_front());
            check("cal_done", int'(cal_done), int'(m_exp));
            m_exp = (done_q.size() > 0) && (done_q[0] == cyc);
            if (m_exp) void'(done_q.pop_front());
            check("done", int'(done), int'(m_exp));
            while (win_q.size() > 0 && win_q[0].last < cyc) void'(win_q.pop_front());
            m_exp = (win_q.size() > 0) && (cyc >= win_q[0].first);
            check("busy", int'(busy), int'(m_exp));
            if (m_exp) check("res_cnt", int'(res_cnt), cyc - win_q[0].first);
        end
    end

    // Hold start/k_len for the current cycle, let the model decide acceptance.
    task automatic drive(bit s, int k);
        start = s;
        k_len = k[K_W-1:0];
        if (s && cyc >= idle_from) accept(k, cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, int'($urandom_range(0, 255)));
    endtask

    task automatic check_all_zero(string name);
        int nz;
        nz = int'(busy | done | cal_en | cal_done | (|a_rd_en) | (|b_rd_en) |
                  (|a_rd_addr) | (|b_rd_addr) | (|res_cnt));
        check(name, nz, 0);
    endtask

    // Assert sys_rst for the current cycle; outputs must clear in the next one.
    task automatic reset_now();
        sys_rst = 1'b1;
        start   = 1'b0;
        purge_after(cyc);
        idle_from = cyc + 1;
        @(posedge clk);
        #1;
        sys_rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort_outputs_zero");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int gap;
        sys_rst = 1'b1;
        start   = 1'b0;
        k_len   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs_zero");
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        sys_rst   = 1'b0;
        idle_from = cyc;

        drive(1'b1, 3);   idle(15);
        drive(1'b1, 4);   idle(16);
        drive(1'b1, 0);   idle(4);

        // Starts in job cycles 2 and 5 are ignored; job cycle 13 is accepted.
        drive(1'b1, 3);   idle(2);
        drive(1'b1, 7);   idle(2);
        drive(1'b1, 9);   idle(7);
        drive(1'b1, 3);   idle(16);

        // Abort in job cycle 3, then a fresh job with full timing.
        drive(1'b1, 8);   idle(3);
        reset_now();
        drive(1'b1, 8);   idle(20);

        drive(1'b1, 255); idle(270);

        repeat (12) begin
            k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            drive(1'b1, k);
            gap = int'($urandom_range(2, k + 2 * N + 4));
            repeat (gap) drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)));
        end
        idle(80);

        for (int i = 0; i < N; i++) begin
            check($sformatf("a_rd%0d_left", i), a_q[i].size(), 0);
            check($sformatf("b_rd%0d_left", i), b_q[i].size(), 0);
        end
        check("cal_en_left", cal_q.size(), 0);
        check("cal_done_left", cald_q.size(), 0);
        check("done_left", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
